// File: rtl/uart_frame_ctrl_pkg.sv
// Shared types and constants for the UART hex-word framing controller.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam int         DIG_W    = 4;   // bits per hex digit
  localparam int         WORD_W   = 32;  // assembled word width

endpackage

// File: rtl/uart_frame_ctrl_hex_decode.sv
// Combinational ASCII classifier: hex digit value, hex flag and CR flag.
module hex_char_decode
  import uart_frame_pkg::*;
(
  input  logic [7:0]       byte_i,
  output logic [DIG_W-1:0] nibble_o,
  output logic             is_hex_o,
  output logic             is_cr_o
);

  // '0'..'9' carry their value in the low nibble; letters (either case) are low nibble + 9
  always_comb begin
    nibble_o = '0;
    is_hex_o = 1'b0;
    is_cr_o  = (byte_i == ASCII_CR);
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      nibble_o = byte_i[3:0];
      is_hex_o = 1'b1;
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      nibble_o = byte_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART hex-word framing controller: collects ASCII hex digits into a 32-bit
// word, terminates on digit count or CR, aborts on bad byte or inter-byte
// timeout, and offers the word on a valid/ready handshake.
// Optional byte echo toward a uart_tx is enabled by UART_FRAME_CTRL_ECHO_EN.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int NDIG          = 8,
  parameter int TIMEOUT_TICKS = 4096,
  parameter int TO_W          = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_dout,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [3:0]        digit_cnt,
  output logic              busy,
  output logic              err_char,
  output logic              err_timeout,
  output logic              overrun
`ifdef UART_FRAME_CTRL_ECHO_EN
  ,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_din
`endif
);

  localparam logic [3:0]      NDIG_C  = 4'(NDIG);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  state_e              state_q;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   word_data_q;
  logic [3:0]          digit_cnt_q, digit_cnt_d;
  logic [TO_W-1:0]     to_cnt_q;
  logic                word_valid_q;
  logic                err_char_q, err_to_q, overrun_q;

  logic [DIG_W-1:0]    nib;
  logic                is_hex, is_cr;

  hex_char_decode u_dec (
    .byte_i   (rx_dout),
    .nibble_o (nib),
    .is_hex_o (is_hex),
    .is_cr_o  (is_cr)
  );

  assign shift_d     = {shift_q[WORD_W-DIG_W-1:0], nib};
  assign digit_cnt_d = digit_cnt_q + 4'd1;

  // Frame sequencer: digit collection, termination, abort and hand-off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      word_data_q  <= '0;
      digit_cnt_q  <= '0;
      to_cnt_q     <= '0;
      word_valid_q <= 1'b0;
      err_char_q   <= 1'b0;
      err_to_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      err_char_q <= 1'b0;
      err_to_q   <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          // CR and junk between frames are silently dropped
          if (rx_done_tick && is_hex) begin
            shift_q     <= {{(WORD_W-DIG_W){1'b0}}, nib};
            digit_cnt_q <= 4'd1;
            if (NDIG == 1) begin
              state_q      <= HOLD;
              word_data_q  <= {{(WORD_W-DIG_W){1'b0}}, nib};
              word_valid_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        COLLECT: begin
          // A byte always beats a coincident timeout expiry
          if (rx_done_tick) begin
            to_cnt_q <= '0;
            if (is_hex) begin
              shift_q     <= shift_d;
              digit_cnt_q <= digit_cnt_d;
              if (digit_cnt_d == NDIG_C) begin
                state_q      <= HOLD;
                word_data_q  <= shift_d;
                word_valid_q <= 1'b1;
              end
            end else if (is_cr) begin
              state_q      <= HOLD;
              word_data_q  <= shift_q;
              word_valid_q <= 1'b1;
            end else begin
              err_char_q  <= 1'b1;
              shift_q     <= '0;
              digit_cnt_q <= '0;
              state_q     <= IDLE;
            end
          end else if (s_tick) begin
            if (to_cnt_q == TO_LAST) begin
              err_to_q    <= 1'b1;
              to_cnt_q    <= '0;
              shift_q     <= '0;
              digit_cnt_q <= '0;
              state_q     <= IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Receiver cannot be stalled, so anything arriving now is lost
          if (rx_done_tick) overrun_q <= 1'b1;
          if (word_ready) begin
            word_valid_q <= 1'b0;
            digit_cnt_q  <= '0;
            shift_q      <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_data   = word_data_q;
  assign word_valid  = word_valid_q;
  assign digit_cnt   = digit_cnt_q;
  assign busy        = (state_q != IDLE);
  assign err_char    = err_char_q;
  assign err_timeout = err_to_q;
  assign overrun     = overrun_q;

`ifdef UART_FRAME_CTRL_ECHO_EN
  logic       echo_full_q;
  logic [7:0] echo_buf_q;
  logic [7:0] tx_din_q;
  logic       tx_start_q;
  logic       echo_take;
  logic       echo_launch;

  // Only bytes the framer actually consumes are echoed; CR counts only inside a frame
  assign echo_take   = rx_done_tick &&
                       (((state_q == IDLE) && is_hex) ||
                        ((state_q == COLLECT) && (is_hex || is_cr)));
  assign echo_launch = echo_full_q && !tx_busy;

  // Single-entry echo buffer; newest byte wins, launch copies into a stable tx_din
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_full_q <= 1'b0;
      echo_buf_q  <= '0;
      tx_din_q    <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      tx_start_q <= echo_launch;
      if (echo_launch) tx_din_q <= echo_buf_q;
      if (echo_take) begin
        echo_buf_q  <= rx_dout;
        echo_full_q <= 1'b1;
      end else if (echo_launch) begin
        echo_full_q <= 1'b0;
      end
    end
  end

  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomized + directed bench for uart_frame_ctrl with a scoreboard of
// expected words and pulses fed by a digit-list reference model.
module tb_uart_frame_ctrl;

  localparam int NDIG = 8;
  localparam int TO   = 16;
  localparam int TO_W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tick, rx_done_tick, word_ready;
  logic [7:0]  rx_dout;
  logic [31:0] word_data;
  logic        word_valid, busy, err_char, err_timeout, overrun;
  logic [3:0]  digit_cnt;
`ifdef UART_FRAME_CTRL_ECHO_EN
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_din;
`endif

  always #5 clk = ~clk;

  uart_frame_ctrl #(.NDIG(NDIG), .TIMEOUT_TICKS(TO), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx_done_tick(rx_done_tick),
    .rx_dout(rx_dout), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .digit_cnt(digit_cnt), .busy(busy),
    .err_char(err_char), .err_timeout(err_timeout), .overrun(overrun)
`ifdef UART_FRAME_CTRL_ECHO_EN
    , .tx_busy(tx_busy), .tx_start(tx_start), .tx_din(tx_din)
`endif
  );

  int total = 0;
  int bad   = 0;

  // reference model: list of collected digit values, pending-word flag, tick count
  int          m_dig[$];
  bit          m_hold  = 0;
  int          m_ticks = 0;
  logic [31:0] wq[$];
  int          pq[$];   // 1=err_char 2=err_timeout 3=overrun

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  task automatic hold_word();
    logic [31:0] v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    wq.push_back(v);
    m_hold = 1;
  endtask

  task automatic m_step(input bit st, input bit rxv, input logic [7:0] b, input bit rdy);
    if (m_hold) begin
      if (rxv) pq.push_back(3);
      if (rdy) begin m_hold = 0; m_dig.delete(); end
    end else if (m_dig.size() == 0) begin
      if (rxv && is_hex(b)) begin
        m_dig.push_back(hexval(b));
        m_ticks = 0;
        if (NDIG == 1) hold_word();
      end
    end else if (rxv) begin
      m_ticks = 0;
      if (is_hex(b)) begin
        m_dig.push_back(hexval(b));
        if (m_dig.size() == NDIG) hold_word();
      end else if (b == 8'h0D) begin
        hold_word();
      end else begin
        pq.push_back(1);
        m_dig.delete();
      end
    end else if (st) begin
      m_ticks++;
      if (m_ticks == TO) begin
        pq.push_back(2);
        m_dig.delete();
        m_ticks = 0;
      end
    end
  endtask

  task automatic step(input bit st, input bit rxv, input logic [7:0] b, input bit rdy);
    s_tick = st; rx_done_tick = rxv; rx_dout = b; word_ready = rdy;
    @(posedge clk);
    m_step(st, rxv, b, rdy);
    #1;
  endtask

  task automatic send(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(1'($urandom % 2), 1'b1, s[i], rdy);
  endtask

  task automatic pop_pulse(input int k, input string nm);
    if (pq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got unexpected pulse expected none at %0t", nm, $time);
    end else begin
      chk(nm, 32'(pq.pop_front()), 32'(k));
    end
  endtask

  // monitor: cycle-level state comparison plus scoreboard pops on handshakes and pulses
  always @(negedge clk) begin
    chk("word_valid", 32'(word_valid), 32'(m_hold));
    chk("digit_cnt", 32'(digit_cnt), 32'(m_dig.size()));
    chk("busy", 32'(busy), 32'(m_hold || m_dig.size() > 0));
    if (err_char)    pop_pulse(1, "err_char");
    if (err_timeout) pop_pulse(2, "err_timeout");
    if (overrun)     pop_pulse(3, "overrun");
    if (word_valid && word_ready) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL word: got %h expected none at %0t", word_data, $time);
      end else begin
        chk("word", word_data, wq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string hx = "0123456789abcdefABCDEF";
    reset = 1'b0; s_tick = 0; rx_done_tick = 0; rx_dout = 0; word_ready = 0;
    #2;
    chk("rst_word_data", word_data, 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_digit_cnt", 32'(digit_cnt), 32'h0);
    chk("rst_pulses", {29'b0, err_char, err_timeout, overrun}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // full word, then overrun while held, then handshake
    send("1A2B3C4D", 1'b0);
    chk("full_valid_lat", 32'(word_valid), 32'h1);
    chk("full_data", word_data, 32'h1A2B3C4D);
    chk("full_cnt", 32'(digit_cnt), 32'd8);
    send("9", 1'b0);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_data_kept", word_data, 32'h1A2B3C4D);
    step(0, 0, 8'h00, 1);
    chk("hs_valid_low", 32'(word_valid), 32'h0);
    chk("hs_busy_low", 32'(busy), 32'h0);
    chk("hs_data_kept", word_data, 32'h1A2B3C4D);

    // short word terminated by CR
    send("ff", 1'b0);
    step(0, 1, 8'h0D, 0);
    chk("short_data", word_data, 32'h000000FF);
    chk("short_cnt", 32'(digit_cnt), 32'd2);
    step(0, 0, 8'h00, 1);

    // bad character aborts, next frame is clean
    send("12G", 1'b0);
    chk("echar_pulse", 32'(err_char), 32'h1);
    chk("echar_cnt", 32'(digit_cnt), 32'h0);
    step(0, 0, 8'h00, 0);
    chk("echar_once", 32'(err_char), 32'h0);
    send("DEADBEEF", 1'b0);
    chk("dead_data", word_data, 32'hDEADBEEF);
    step(0, 0, 8'h00, 1);

    // timeout: byte coinciding with expiry wins, then a real timeout
    send("7", 1'b0);
    repeat (TO - 1) step(1, 0, 8'h00, 0);
    step(1, 1, "8", 0);
    chk("to_byte_wins", 32'(err_timeout), 32'h0);
    repeat (TO - 1) step(1, 0, 8'h00, 0);
    chk("to_not_yet", 32'(err_timeout), 32'h0);
    step(1, 0, 8'h00, 0);
    chk("to_pulse", 32'(err_timeout), 32'h1);
    chk("to_idle", 32'(busy), 32'h0);

    // asynchronous reset mid-frame
    send("3", 1'b0);
    step(0, 0, 8'h00, 0);
    #2 reset = 1'b0;
    m_dig.delete(); m_hold = 0; m_ticks = 0;
    #1;
    chk("arst_cnt", 32'(digit_cnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_data", word_data, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // randomized traffic at a busy and a sparse byte rate
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 3000; n++) begin
        int r = $urandom % 16;
        logic [7:0] b;
        if (r < 11)       b = hx[$urandom % 22];
        else if (r < 13)  b = 8'h0D;
        else              b = 8'($urandom);
        step(1'($urandom % 2), ($urandom % 100) < (ph == 0 ? 40 : 6), b, ($urandom % 3) == 0);
      end
    end

    repeat (4) step(0, 0, 8'h00, 1);
    chk("words_drained", 32'(wq.size()), 32'h0);
    chk("pulses_drained", 32'(pq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
